// File: rtl/bcd_timer_counter_n_if.sv
// Command and status bundle for the BCD timer digit chain.
// The controller drives the master side; the counter owns the slave side.
interface bcd_timer_counter_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    EN;
  logic                    loadn;
  logic                    up;
  logic [4*NUM_DIGITS-1:0] data;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    zero;
  logic                    done;
  logic                    wrap;
  logic                    load_err;

  modport master (
    output EN, loadn, up, data,
    input  digits, zero, done, wrap, load_err
  );

  modport slave (
    input  EN, loadn, up, data,
    output digits, zero, done, wrap, load_err
  );
endinterface

// File: rtl/bcd_timer_counter_n.sv
// Chain of NUM_DIGITS BCD digits with per-digit maxima (e.g. MM:SS), parallel load,
// up/down counting and wrap-or-saturate behaviour at both ends.
module bcd_timer_counter_n #(
  parameter int                      NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h9959,
  parameter bit                      SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  bcd_timer_counter_n_if.slave  bus
);

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic                    r_done;
  logic                    r_wrap;
  logic                    r_loadErr;

  logic [4*NUM_DIGITS-1:0] w_next;
  logic                    w_done;
  logic                    w_wrap;
  logic                    w_loadErr;
  logic                    w_allZero;
  logic                    w_allMax;

  assign w_allZero = (r_digits == '0);
  assign w_allMax  = (r_digits == DIGIT_MAX);

  // A borrow/carry ripples upward only while every lower digit sits at its end value.
  always_comb begin
    logic w_ripple;
    w_next    = r_digits;
    w_done    = 1'b0;
    w_wrap    = 1'b0;
    w_loadErr = 1'b0;
    w_ripple  = 1'b1;
    if (!bus.loadn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.data[4*i +: 4] > DIGIT_MAX[4*i +: 4]) begin
          w_next[4*i +: 4] = DIGIT_MAX[4*i +: 4];
          w_loadErr        = 1'b1;
        end else begin
          w_next[4*i +: 4] = bus.data[4*i +: 4];
        end
      end
    end else if (bus.EN) begin
      if (!bus.up) begin
        if (w_allZero) begin
          w_wrap = 1'b1;
          if (!SATURATE) begin
            w_next = DIGIT_MAX;
          end
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_ripple) begin
              if (r_digits[4*i +: 4] == 4'd0) begin
                w_next[4*i +: 4] = DIGIT_MAX[4*i +: 4];
              end else begin
                w_next[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
              end
            end
            w_ripple = w_ripple & (r_digits[4*i +: 4] == 4'd0);
          end
          w_done = (w_next == '0);
        end
      end else begin
        if (w_allMax) begin
          w_wrap = 1'b1;
          if (!SATURATE) begin
            w_next = '0;
          end
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_ripple) begin
              if (r_digits[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
                w_next[4*i +: 4] = 4'd0;
              end else begin
                w_next[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
              end
            end
            w_ripple = w_ripple & (r_digits[4*i +: 4] == DIGIT_MAX[4*i +: 4]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_digits  <= '0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_digits  <= w_next;
      r_done    <= w_done;
      r_wrap    <= w_wrap;
      r_loadErr <= w_loadErr;
    end
  end

  assign bus.digits   = r_digits;
  assign bus.zero     = (r_digits == '0);
  assign bus.done     = r_done;
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_loadErr;

endmodule

// File: tb/tb_bcd_timer_counter_n.sv
// Directed bench for bcd_timer_counter_n: a saturating instance (A) and a wrapping instance (B).
// Observed word per check is {digits, zero, done, wrap, load_err}.
module tb_bcd_timer_counter_n;

  logic clk;
  logic clear;
  int   checkCount;
  int   passCount;

  bcd_timer_counter_n_if #(.NUM_DIGITS(4)) ifA ();
  bcd_timer_counter_n_if #(.NUM_DIGITS(4)) ifB ();

  bcd_timer_counter_n #(.NUM_DIGITS(4), .DIGIT_MAX(16'h9959), .SATURATE(1'b1)) dutA (
    .clk   (clk),
    .clear (clear),
    .bus   (ifA)
  );

  bcd_timer_counter_n #(.NUM_DIGITS(4), .DIGIT_MAX(16'h9959), .SATURATE(1'b0)) dutB (
    .clk   (clk),
    .clear (clear),
    .bus   (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifA.EN = 1'b0; ifA.loadn = 1'b1; ifA.up = 1'b0; ifA.data = 16'h0000;
    ifB.EN = 1'b0; ifB.loadn = 1'b1; ifB.up = 1'b0; ifB.data = 16'h0000;
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    clear = 1'b1;
    idle_all();
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00008) $display("[TB] FAIL reset_A: got %h expected %h", obs, 20'h00008);
    else passCount++;
    checkCount++;
    obs = {ifB.digits, ifB.zero, ifB.done, ifB.wrap, ifB.load_err};
    if (obs !== 20'h00008) $display("[TB] FAIL reset_B: got %h expected %h", obs, 20'h00008);
    else passCount++;
    #3 clear = 1'b0;
    ifA.loadn = 1'b0; ifA.data = 16'h1235;
    step();
    ifA.loadn = 1'b1; ifA.EN = 1'b1; ifA.up = 1'b0;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h12340) $display("[TB] FAIL midcount_1234: got %h expected %h", obs, 20'h12340);
    else passCount++;
    #2 clear = 1'b1;
    #1;
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00008) $display("[TB] FAIL async_clear: got %h expected %h", obs, 20'h00008);
    else passCount++;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00008) $display("[TB] FAIL clear_held: got %h expected %h", obs, 20'h00008);
    else passCount++;
    #3 clear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checkCount++;
      obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
      if (obs !== 20'h0000A) $display("[TB] FAIL release_sat_%0d: got %h expected %h", k, obs, 20'h0000A);
      else passCount++;
    end
    ifA.EN = 1'b0;
  endtask

  task automatic test_load_clamp();
    logic [19:0] obs;
    ifA.loadn = 1'b0; ifA.data = 16'h12F7;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h12571) $display("[TB] FAIL load_clamp: got %h expected %h", obs, 20'h12571);
    else passCount++;
    ifA.data = 16'h0130;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h01300) $display("[TB] FAIL load_valid: got %h expected %h", obs, 20'h01300);
    else passCount++;
    ifA.loadn = 1'b1;
  endtask

  task automatic test_down_borrow();
    logic [19:0] obs;
    ifA.loadn = 1'b0; ifA.data = 16'h0100;
    step();
    ifA.loadn = 1'b1; ifA.EN = 1'b1; ifA.up = 1'b0;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00590) $display("[TB] FAIL borrow_0059: got %h expected %h", obs, 20'h00590);
    else passCount++;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00580) $display("[TB] FAIL borrow_0058: got %h expected %h", obs, 20'h00580);
    else passCount++;
    ifA.loadn = 1'b0; ifA.data = 16'h0001;
    step();
    ifA.loadn = 1'b1;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h0000C) $display("[TB] FAIL done_pulse: got %h expected %h", obs, 20'h0000C);
    else passCount++;
    ifA.EN = 1'b0;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00008) $display("[TB] FAIL done_clears: got %h expected %h", obs, 20'h00008);
    else passCount++;
  endtask

  task automatic test_saturate_wrap();
    logic [19:0] obs;
    ifA.EN = 1'b1; ifA.up = 1'b0;
    ifB.loadn = 1'b0; ifB.data = 16'h0000;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h0000A) $display("[TB] FAIL sat_hold_zero: got %h expected %h", obs, 20'h0000A);
    else passCount++;
    checkCount++;
    obs = {ifB.digits, ifB.zero, ifB.done, ifB.wrap, ifB.load_err};
    if (obs !== 20'h00008) $display("[TB] FAIL load_zero_B: got %h expected %h", obs, 20'h00008);
    else passCount++;
    ifA.EN = 1'b0;
    ifB.loadn = 1'b1; ifB.EN = 1'b1; ifB.up = 1'b0;
    step();
    checkCount++;
    obs = {ifB.digits, ifB.zero, ifB.done, ifB.wrap, ifB.load_err};
    if (obs !== 20'h99592) $display("[TB] FAIL wrap_down_B: got %h expected %h", obs, 20'h99592);
    else passCount++;
    ifB.EN = 1'b0;
  endtask

  task automatic test_up_carry();
    logic [19:0] obs;
    ifA.loadn = 1'b0; ifA.data = 16'h0959;
    step();
    ifA.loadn = 1'b1; ifA.EN = 1'b1; ifA.up = 1'b1;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h10000) $display("[TB] FAIL carry_1000: got %h expected %h", obs, 20'h10000);
    else passCount++;
    ifA.loadn = 1'b0; ifA.data = 16'h9959;
    ifB.loadn = 1'b0; ifB.data = 16'h9959;
    step();
    ifA.loadn = 1'b1;
    ifB.loadn = 1'b1; ifB.EN = 1'b1; ifB.up = 1'b1;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h99592) $display("[TB] FAIL sat_hold_max: got %h expected %h", obs, 20'h99592);
    else passCount++;
    checkCount++;
    obs = {ifB.digits, ifB.zero, ifB.done, ifB.wrap, ifB.load_err};
    if (obs !== 20'h0000A) $display("[TB] FAIL wrap_up_B: got %h expected %h", obs, 20'h0000A);
    else passCount++;
    ifA.EN = 1'b0; ifA.up = 1'b0;
    ifB.EN = 1'b0; ifB.up = 1'b0;
  endtask

  task automatic test_enable_priority();
    logic [19:0] obs;
    ifA.loadn = 1'b0; ifA.data = 16'h0005;
    step();
    ifA.loadn = 1'b1; ifA.EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checkCount++;
      obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
      if (obs !== 20'h00050) $display("[TB] FAIL frozen_%0d: got %h expected %h", k, obs, 20'h00050);
      else passCount++;
    end
    ifA.loadn = 1'b0; ifA.EN = 1'b1; ifA.up = 1'b0; ifA.data = 16'h0042;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00420) $display("[TB] FAIL load_over_count: got %h expected %h", obs, 20'h00420);
    else passCount++;
    ifA.loadn = 1'b1; ifA.EN = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] obs;
    logic [19:0] expSeq [3];
    expSeq[0] = 20'h00010;
    expSeq[1] = 20'h0000C;
    expSeq[2] = 20'h0000A;
    ifA.loadn = 1'b0; ifA.data = 16'h0002;
    step();
    ifA.loadn = 1'b1; ifA.EN = 1'b1; ifA.up = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checkCount++;
      obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
      if (obs !== expSeq[k]) $display("[TB] FAIL b2b_step_%0d: got %h expected %h", k, obs, expSeq[k]);
      else passCount++;
    end
    ifA.EN = 1'b0;
    step();
    checkCount++;
    obs = {ifA.digits, ifA.zero, ifA.done, ifA.wrap, ifA.load_err};
    if (obs !== 20'h00008) $display("[TB] FAIL b2b_idle: got %h expected %h", obs, 20'h00008);
    else passCount++;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_load_clamp();
    test_down_borrow();
    test_saturate_wrap();
    test_up_carry();
    test_enable_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
